// File: rtl/decoding_block.sv
// Receive-side lane decoder: checks 64b/66b or 128b/132b sync headers
// and unloads each accepted symbol as one byte per lane per clock.
module decoding_block (
   input  logic         dec_clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [1:0]   gen_speed,
   input  logic [131:0] lane_0_rx_enc,
   input  logic [131:0] lane_1_rx_enc,
   input  logic         sym_valid,
   output logic         sym_ready,
   output logic [7:0]   lane_0_rx,
   output logic [7:0]   lane_1_rx,
   output logic         rx_valid,
   output logic         rx_os,
   output logic         sync_err,
   output logic [7:0]   hdr_err_cnt
);

   localparam logic [1:0] GEN_LEGACY = 2'd0;
   localparam logic [1:0] GEN_4      = 2'd1;
   localparam logic [1:0] GEN_3      = 2'd2;
   localparam logic [1:0] GEN_RSVD   = 2'd3;

   logic [127:0] pay0_q, pay0_d;
   logic [127:0] pay1_q, pay1_d;
   logic [4:0]   idx_q, idx_d;
   logic         os_q, os_d;
   logic [7:0]   lane0_q, lane0_d;
   logic [7:0]   lane1_q, lane1_d;
   logic         rx_valid_q, rx_valid_d;
   logic         sync_err_q, sync_err_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [1:0]   gen_q, gen_d;

   logic [4:0]   n_len;
   logic [1:0]   hd0, hd1;
   logic         hdr_good;
   logic         accept;
   logic [127:0] pay_in0, pay_in1;
   logic [6:0]   bsel;

   // Returns {valid, ordered_set} for the header in the symbol LSBs.
   function automatic logic [1:0] hdr_dec(input logic [1:0] gen,
                                          input logic [3:0] h);
      logic [1:0] r;
      r = 2'b00;
      if (gen == GEN_3) begin
         case (h[1:0])
            2'b01:   r = 2'b10;
            2'b10:   r = 2'b11;
            default: r = 2'b00;
         endcase
      end else if (gen == GEN_4) begin
         case (h)
            4'b1010: r = 2'b10;
            4'b0101: r = 2'b11;
            default: r = 2'b00;
         endcase
      end
      return r;
   endfunction

   assign n_len    = (gen_speed == GEN_3) ? 5'd8 : 5'd16;
   assign hd0      = hdr_dec(gen_speed, lane_0_rx_enc[3:0]);
   assign hd1      = hdr_dec(gen_speed, lane_1_rx_enc[3:0]);
   assign hdr_good = hd0[1] & hd1[1] & (hd0[0] == hd1[0]);
   assign bsel     = {idx_q[3:0], 3'b000};

   assign pay_in0 = (gen_speed == GEN_3) ?
                    {64'b0, lane_0_rx_enc[65:2]} : lane_0_rx_enc[131:4];
   assign pay_in1 = (gen_speed == GEN_3) ?
                    {64'b0, lane_1_rx_enc[65:2]} : lane_1_rx_enc[131:4];

   // Ready while idle or on the last byte, so symbols chain without gaps.
   assign sym_ready = ~rst & enable & (gen_speed != GEN_RSVD) &
                      ((gen_speed == GEN_LEGACY) | (idx_q == 5'd0) |
                       (idx_q == n_len));
   assign accept    = sym_valid & sym_ready;

   always_comb begin
      pay0_d     = pay0_q;
      pay1_d     = pay1_q;
      idx_d      = idx_q;
      os_d       = os_q;
      lane0_d    = lane0_q;
      lane1_d    = lane1_q;
      rx_valid_d = 1'b0;
      sync_err_d = 1'b0;
      cnt_d      = cnt_q;
      gen_d      = gen_speed;

      if (!enable) begin
         pay0_d  = '0;
         pay1_d  = '0;
         idx_d   = '0;
         os_d    = 1'b0;
         lane0_d = '0;
         lane1_d = '0;
         cnt_d   = '0;
      end else if (gen_speed == GEN_RSVD) begin
         idx_d = '0;
      end else if (gen_speed == GEN_LEGACY) begin
         idx_d      = '0;
         os_d       = 1'b0;
         lane0_d    = lane_0_rx_enc[7:0];
         lane1_d    = lane_1_rx_enc[7:0];
         rx_valid_d = sym_valid;
      end else if (accept) begin
         if (hdr_good) begin
            pay0_d     = pay_in0;
            pay1_d     = pay_in1;
            lane0_d    = pay_in0[7:0];
            lane1_d    = pay_in1[7:0];
            os_d       = hd0[0];
            idx_d      = 5'd1;
            rx_valid_d = 1'b1;
         end else begin
            idx_d      = '0;
            sync_err_d = 1'b1;
            cnt_d      = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
         end
      end else if ((idx_q != 5'd0) && (gen_speed != gen_q)) begin
         idx_d = '0;
      end else if ((idx_q != 5'd0) && (idx_q < n_len)) begin
         lane0_d    = pay0_q[bsel +: 8];
         lane1_d    = pay1_q[bsel +: 8];
         idx_d      = idx_q + 5'd1;
         rx_valid_d = 1'b1;
      end else begin
         idx_d = '0;
      end
   end

   always_ff @(posedge dec_clk) begin
      if (rst) begin
         pay0_q     <= '0;
         pay1_q     <= '0;
         idx_q      <= '0;
         os_q       <= 1'b0;
         lane0_q    <= '0;
         lane1_q    <= '0;
         rx_valid_q <= 1'b0;
         sync_err_q <= 1'b0;
         cnt_q      <= '0;
         gen_q      <= '0;
      end else begin
         pay0_q     <= pay0_d;
         pay1_q     <= pay1_d;
         idx_q      <= idx_d;
         os_q       <= os_d;
         lane0_q    <= lane0_d;
         lane1_q    <= lane1_d;
         rx_valid_q <= rx_valid_d;
         sync_err_q <= sync_err_d;
         cnt_q      <= cnt_d;
         gen_q      <= gen_d;
      end
   end

   assign lane_0_rx   = lane0_q;
   assign lane_1_rx   = lane1_q;
   assign rx_valid    = rx_valid_q;
   assign rx_os       = os_q;
   assign sync_err    = sync_err_q;
   assign hdr_err_cnt = cnt_q;

endmodule

// File: tb/tb_decoding_block.sv
// Directed bench for decoding_block: Gen3/Gen4 unload, header errors,
// legacy bypass, reserved mode and mid-symbol aborts.
module tb_decoding_block;

   logic         dec_clk;
   logic         rst;
   logic         enable;
   logic [1:0]   gen_speed;
   logic [131:0] lane_0_rx_enc;
   logic [131:0] lane_1_rx_enc;
   logic         sym_valid;
   logic         sym_ready;
   logic [7:0]   lane_0_rx;
   logic [7:0]   lane_1_rx;
   logic         rx_valid;
   logic         rx_os;
   logic         sync_err;
   logic [7:0]   hdr_err_cnt;

   int n_cmp = 0;
   int n_err = 0;

   decoding_block dut (
      .dec_clk       (dec_clk),
      .rst           (rst),
      .enable        (enable),
      .gen_speed     (gen_speed),
      .lane_0_rx_enc (lane_0_rx_enc),
      .lane_1_rx_enc (lane_1_rx_enc),
      .sym_valid     (sym_valid),
      .sym_ready     (sym_ready),
      .lane_0_rx     (lane_0_rx),
      .lane_1_rx     (lane_1_rx),
      .rx_valid      (rx_valid),
      .rx_os         (rx_os),
      .sync_err      (sync_err),
      .hdr_err_cnt   (hdr_err_cnt)
   );

   initial dec_clk = 1'b0;
   always #5 dec_clk = ~dec_clk;

   task automatic step();
      @(posedge dec_clk);
      #1;
   endtask

   function automatic logic [127:0] ramp(input logic [7:0] base);
      logic [127:0] p;
      p = '0;
      for (int i = 0; i < 16; i++) p[8*i +: 8] = base + 8'(i);
      return p;
   endfunction

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; gen_speed = 2'd2; sym_valid = 1'b0;
      lane_0_rx_enc = '0; lane_1_rx_enc = '0;
      step(); step();
      n_cmp++;
      if (sym_ready !== 1'b0) begin n_err++;
         $display("FAIL rst_ready got %b want 0", sym_ready); end
      n_cmp++;
      if ({lane_0_rx, lane_1_rx, rx_valid, rx_os, sync_err, hdr_err_cnt} !== 27'd0)
      begin n_err++;
         $display("FAIL rst_outputs got %h %h %b %b %b %h want all 0",
                  lane_0_rx, lane_1_rx, rx_valid, rx_os, sync_err, hdr_err_cnt); end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (sym_ready !== 1'b1) begin n_err++;
         $display("FAIL post_rst_ready got %b want 1", sym_ready); end
   endtask

   task automatic test_gen3_data();
      gen_speed = 2'd2;
      lane_0_rx_enc = {66'h0, 64'h0706050403020100, 2'b01};
      lane_1_rx_enc = {66'h0, 64'h0f0e0d0c0b0a0908, 2'b01};
      sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k != 0) step();
         n_cmp++;
         if ({rx_valid, rx_os, lane_0_rx, lane_1_rx} !== {2'b10, 8'(k), 8'(k + 8)})
         begin n_err++;
            $display("FAIL g3_byte%0d got v=%b os=%b %h %h want v=1 os=0 %h %h",
                     k, rx_valid, rx_os, lane_0_rx, lane_1_rx, 8'(k), 8'(k + 8)); end
         n_cmp++;
         if (sym_ready !== (k == 7)) begin n_err++;
            $display("FAIL g3_ready%0d got %b want %b", k, sym_ready, (k == 7)); end
      end
      step();
      n_cmp++;
      if (rx_valid !== 1'b0 || lane_0_rx !== 8'h07) begin n_err++;
         $display("FAIL g3_idle got v=%b %h want v=0 07", rx_valid, lane_0_rx); end
   endtask

   task automatic test_gen4_back_to_back();
      logic [127:0] pa, pb;
      pa = ramp(8'h00);
      pb = ramp(8'h10);
      gen_speed = 2'd1;
      lane_0_rx_enc = {pa, 4'b0101};
      lane_1_rx_enc = {~pa, 4'b0101};
      sym_valid = 1'b1;
      for (int c = 0; c < 32; c++) begin
         step();
         if (c == 0) begin
            lane_0_rx_enc = {pb, 4'b0101};
            lane_1_rx_enc = {~pb, 4'b0101};
         end
         if (c == 16) sym_valid = 1'b0;
         n_cmp++;
         if ({rx_valid, rx_os, lane_0_rx, lane_1_rx} !== {2'b11, 8'(c), ~8'(c)})
         begin n_err++;
            $display("FAIL g4_b2b%0d got v=%b os=%b %h %h want v=1 os=1 %h %h",
                     c, rx_valid, rx_os, lane_0_rx, lane_1_rx, 8'(c), ~8'(c)); end
      end
      step();
      n_cmp++;
      if (rx_valid !== 1'b0) begin n_err++;
         $display("FAIL g4_idle got v=%b want 0", rx_valid); end
   endtask

   task automatic test_bad_header();
      gen_speed = 2'd2;
      lane_0_rx_enc = {66'h0, 64'h1111111111111111, 2'b01};
      lane_1_rx_enc = {66'h0, 64'h2222222222222222, 2'b11};
      sym_valid = 1'b1;
      step();
      n_cmp++;
      if ({sync_err, rx_valid, hdr_err_cnt} !== {2'b10, 8'd1}) begin n_err++;
         $display("FAIL bad_hdr got err=%b v=%b cnt=%0d want err=1 v=0 cnt=1",
                  sync_err, rx_valid, hdr_err_cnt); end
      lane_0_rx_enc = {66'h0, 64'h8786858483828180, 2'b01};
      lane_1_rx_enc = {66'h0, 64'h8786858483828180, 2'b01};
      step();
      sym_valid = 1'b0;
      n_cmp++;
      if (sync_err !== 1'b0) begin n_err++;
         $display("FAIL bad_hdr_pulse got %b want 0", sync_err); end
      for (int k = 0; k < 8; k++) begin
         if (k != 0) step();
         n_cmp++;
         if ({rx_valid, lane_0_rx, lane_1_rx} !== {1'b1, 8'(8'h80 + k), 8'(8'h80 + k)})
         begin n_err++;
            $display("FAIL bad_hdr_good%0d got v=%b %h want v=1 %h",
                     k, rx_valid, lane_0_rx, 8'(8'h80 + k)); end
      end
      step();
      n_cmp++;
      if (hdr_err_cnt !== 8'd1) begin n_err++;
         $display("FAIL bad_hdr_cnt got %0d want 1", hdr_err_cnt); end
   endtask

   task automatic test_mismatch();
      gen_speed = 2'd1;
      lane_0_rx_enc = {128'h5, 4'b1010};
      lane_1_rx_enc = {128'h6, 4'b0101};
      sym_valid = 1'b1;
      step();
      n_cmp++;
      if ({sync_err, rx_valid, hdr_err_cnt} !== {2'b10, 8'd2}) begin n_err++;
         $display("FAIL mismatch got err=%b v=%b cnt=%0d want err=1 v=0 cnt=2",
                  sync_err, rx_valid, hdr_err_cnt); end
      for (int i = 0; i < 300; i++) step();
      n_cmp++;
      if ({sync_err, hdr_err_cnt} !== {1'b1, 8'd255}) begin n_err++;
         $display("FAIL sat got err=%b cnt=%0d want err=1 cnt=255",
                  sync_err, hdr_err_cnt); end
      sym_valid = 1'b0;
      step();
      n_cmp++;
      if ({sync_err, hdr_err_cnt} !== {1'b0, 8'd255}) begin n_err++;
         $display("FAIL sat_hold got err=%b cnt=%0d want err=0 cnt=255",
                  sync_err, hdr_err_cnt); end
   endtask

   task automatic test_legacy();
      gen_speed = 2'd0;
      lane_0_rx_enc = {124'h0, 8'hA5};
      lane_1_rx_enc = {124'h0, 8'h5A};
      sym_valid = 1'b1;
      #1;
      n_cmp++;
      if (sym_ready !== 1'b1) begin n_err++;
         $display("FAIL leg_ready0 got %b want 1", sym_ready); end
      step();
      n_cmp++;
      if ({rx_valid, rx_os, lane_0_rx, lane_1_rx} !== {2'b10, 8'hA5, 8'h5A})
      begin n_err++;
         $display("FAIL leg_byte got v=%b os=%b %h %h want v=1 os=0 a5 5a",
                  rx_valid, rx_os, lane_0_rx, lane_1_rx); end
      sym_valid = 1'b0;
      lane_0_rx_enc = {124'h0, 8'h3C};
      step();
      n_cmp++;
      if ({rx_valid, lane_0_rx, sym_ready, sync_err, hdr_err_cnt} !==
          {1'b0, 8'h3C, 2'b10, 8'd255}) begin n_err++;
         $display("FAIL leg_novalid got v=%b %h rdy=%b err=%b cnt=%0d want v=0 3c rdy=1 err=0 cnt=255",
                  rx_valid, lane_0_rx, sym_ready, sync_err, hdr_err_cnt); end
   endtask

   task automatic test_reserved();
      gen_speed = 2'd3;
      sym_valid = 1'b1;
      #1;
      n_cmp++;
      if (sym_ready !== 1'b0) begin n_err++;
         $display("FAIL rsvd_ready got %b want 0", sym_ready); end
      step();
      n_cmp++;
      if ({rx_valid, sync_err} !== 2'b00) begin n_err++;
         $display("FAIL rsvd_out got v=%b err=%b want 0 0", rx_valid, sync_err); end
      sym_valid = 1'b0;
   endtask

   task automatic test_abort_enable();
      gen_speed = 2'd1;
      lane_0_rx_enc = {ramp(8'h20), 4'b1010};
      lane_1_rx_enc = {ramp(8'h20), 4'b1010};
      sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if ({rx_valid, lane_0_rx} !== {1'b1, 8'h24}) begin n_err++;
         $display("FAIL ab_en_pre got v=%b %h want v=1 24", rx_valid, lane_0_rx); end
      enable = 1'b0;
      #1;
      n_cmp++;
      if (sym_ready !== 1'b0) begin n_err++;
         $display("FAIL ab_en_ready got %b want 0", sym_ready); end
      step();
      n_cmp++;
      if ({lane_0_rx, lane_1_rx, rx_valid, rx_os, sync_err, hdr_err_cnt} !== 27'd0)
      begin n_err++;
         $display("FAIL ab_en_clear got %h %h %b %b %b %0d want all 0",
                  lane_0_rx, lane_1_rx, rx_valid, rx_os, sync_err, hdr_err_cnt); end
      enable = 1'b1;
      lane_0_rx_enc = {ramp(8'h40), 4'b0101};
      lane_1_rx_enc = {ramp(8'h40), 4'b0101};
      sym_valid = 1'b1;
      #1;
      n_cmp++;
      if (sym_ready !== 1'b1) begin n_err++;
         $display("FAIL ab_en_ready1 got %b want 1", sym_ready); end
      step();
      sym_valid = 1'b0;
      n_cmp++;
      if ({rx_valid, rx_os, lane_0_rx} !== {2'b11, 8'h40}) begin n_err++;
         $display("FAIL ab_en_restart got v=%b os=%b %h want v=1 os=1 40",
                  rx_valid, rx_os, lane_0_rx); end
      step();
      n_cmp++;
      if (lane_0_rx !== 8'h41) begin n_err++;
         $display("FAIL ab_en_byte1 got %h want 41", lane_0_rx); end
      for (int i = 0; i < 15; i++) step();
      n_cmp++;
      if (rx_valid !== 1'b0) begin n_err++;
         $display("FAIL ab_en_idle got v=%b want 0", rx_valid); end
   endtask

   task automatic test_abort_gen();
      gen_speed = 2'd1;
      lane_0_rx_enc = {ramp(8'h60), 4'b1010};
      lane_1_rx_enc = {ramp(8'h60), 4'b1010};
      sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (lane_0_rx !== 8'h64) begin n_err++;
         $display("FAIL ab_gen_pre got %h want 64", lane_0_rx); end
      gen_speed = 2'd2;
      #1;
      n_cmp++;
      if (sym_ready !== 1'b0) begin n_err++;
         $display("FAIL ab_gen_ready0 got %b want 0", sym_ready); end
      step();
      n_cmp++;
      if ({rx_valid, sync_err, hdr_err_cnt, sym_ready} !== {2'b00, 8'd0, 1'b1})
      begin n_err++;
         $display("FAIL ab_gen got v=%b err=%b cnt=%0d rdy=%b want 0 0 0 1",
                  rx_valid, sync_err, hdr_err_cnt, sym_ready); end
      lane_0_rx_enc = {66'h0, 64'h7776757473727170, 2'b01};
      lane_1_rx_enc = {66'h0, 64'h7776757473727170, 2'b01};
      sym_valid = 1'b1;
      step();
      sym_valid = 1'b0;
      n_cmp++;
      if ({rx_valid, rx_os, lane_0_rx} !== {2'b10, 8'h70}) begin n_err++;
         $display("FAIL ab_gen_restart got v=%b os=%b %h want v=1 os=0 70",
                  rx_valid, rx_os, lane_0_rx); end
      for (int i = 0; i < 8; i++) step();
      n_cmp++;
      if ({rx_valid, lane_0_rx} !== {1'b0, 8'h77}) begin n_err++;
         $display("FAIL ab_gen_idle got v=%b %h want v=0 77", rx_valid, lane_0_rx); end
   endtask

   initial begin
      test_reset();
      test_gen3_data();
      test_gen4_back_to_back();
      test_bad_header();
      test_mismatch();
      test_legacy();
      test_reserved();
      test_abort_enable();
      test_abort_gen();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decoding_block.md
# decoding_block

Receive-side counterpart of the lane encoder. Takes one encoded symbol per lane from the deserializer: a 66-bit (Gen3, 64b/66b) or 132-bit (Gen4, 128b/132b) word, or raw bytes in legacy mode. The block checks the sync header and unloads the payload as one byte per lane per clock toward the lane deskew/receive logic. It also flags ordered-set symbols and header errors.

## Interface
Parameters: none. Symbol sizes are fixed by `gen_speed`.

Ports:
- `dec_clk` in 1: decoder clock, one byte per lane per cycle.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: decoder enable; low acts as a synchronous clear.
- `gen_speed` in 2: 2 = Gen3 (66b), 1 = Gen4 (132b), 0 = legacy byte bypass, 3 = reserved.
- `lane_0_rx_enc` in 132: lane 0 encoded symbol. The sync header is in the LSBs.
- `lane_1_rx_enc` in 132: lane 1 encoded symbol, same format.
- `sym_valid` in 1: encoded symbols are valid this cycle.
- `sym_ready` out 1: decoder accepts a symbol this cycle.
- `lane_0_rx` out 8: decoded lane 0 byte.
- `lane_1_rx` out 8: decoded lane 1 byte.
- `rx_valid` out 1: `lane_x_rx` hold a valid byte.
- `rx_os` out 1: the current byte belongs to an ordered-set symbol.
- `sync_err` out 1: one-cycle pulse when a symbol is discarded.
- `hdr_err_cnt` out 8: saturating count of discarded symbols.

## Operation
- Handshake: a symbol is accepted on a rising edge where `sym_valid & sym_ready`. `sym_valid` while `sym_ready`=0 is ignored. No data is lost on the decoder side; the source must hold the symbol.
- Symbol length N: 8 bytes for Gen3, 16 bytes for Gen4.
  - Gen3 header is bits [1:0].
  - Gen4 header is bits [3:0].
  - Payload byte k is at [8k+H+7 : 8k+H], where H = 2 (Gen3) or 4 (Gen4).
  - Byte 0 is emitted first.
- Header decode:
  - Gen3: 2'b01 = data, 2'b10 = ordered set.
  - Gen4: 4'b1010 = data, 4'b0101 = ordered set.
  - Any other value is invalid.
- Header check: both lanes must be valid and of the same type. Otherwise:
  - the symbol is discarded (no bytes emitted, `rx_valid`=0);
  - `sync_err`=1 for one cycle;
  - `hdr_err_cnt` increments, saturating at 255.
- Registers: payload register (128 b per lane), byte index `idx` (0..16), `os_reg`.
- Unload:
  - On acceptance of a good symbol, byte 0 is registered directly to the outputs and `idx`=1.
  - Each following cycle emits byte `idx` and increments `idx`.
  - After byte N-1 is emitted, `idx`=N.
- Ready rule: `sym_ready` = `enable` & (`gen_speed`≠3) & (`idx`==0 | `idx`==N). This gives gapless back-to-back symbols.
- Going idle: when `idx`==N and no symbol is accepted, the next edge gives `rx_valid`=0, `idx`=0, and the outputs hold their last byte values.
- `rx_os` equals the header type of the symbol currently being emitted. It is constant for all N bytes.
- Legacy mode (`gen_speed`=0):
  - `sym_ready`=1;
  - each edge: `lane_x_rx` <= `lane_x_rx_enc`[7:0], `rx_valid` <= `sym_valid`, `rx_os` <= 0;
  - no header check.
- Reserved mode (`gen_speed`=3): `sym_ready`=0, `rx_valid`=0, state held idle.
- `gen_speed` change while `idx`≠0: the symbol in flight is aborted. The next edge gives `idx`=0, `rx_valid`=0, and no `sync_err`.
- `rst`=1 or `enable`=0, at the next edge, clears:
  - all outputs;
  - `idx`;
  - the payload register;
  - `hdr_err_cnt`.

## Timing
- Reset values: `sym_ready`=0 during reset, `lane_0_rx`=`lane_1_rx`=0, `rx_valid`=0, `rx_os`=0, `sync_err`=0, `hdr_err_cnt`=0.
- Latency: a symbol accepted at edge E0 puts byte k on the outputs after edge E0+k. There are N valid cycles per symbol.
- Throughput: one symbol per N cycles with no bubbles when `sym_valid` is held.
- `sync_err` is asserted in the cycle after the accepting edge. During the bad-symbol cycle that follows a good symbol, `rx_valid`=0.
- Reset or disable during an unload takes effect at the next edge. Remaining bytes are dropped.
- All outputs are registered. `sym_ready` is combinational from `idx`, `enable` and `gen_speed` only.

## Test plan
- **Gen3 data:** `gen_speed`=2, lane 0 = {64'h0706050403020100, 2'b01} valid one cycle -> bytes 00..07 on 8 consecutive cycles, `rx_os`=0, `sym_ready` low for the middle 7 cycles.
- **Gen4 back-to-back:** `gen_speed`=1, `sym_valid` held with two OS symbols (header 4'b0101) -> 32 consecutive `rx_valid` cycles with no gap, `rx_os`=1 throughout.
- **Bad header:** Gen3 with lane 1 header 2'b11, then a good symbol -> first symbol emits no bytes, `sync_err` pulses once, `hdr_err_cnt`=1, then 8 good bytes.
- **Lane type mismatch:** Gen4 with lane 0 = 1010 and lane 1 = 0101 -> discard and `sync_err`. Separately, 300 bad symbols -> `hdr_err_cnt`=255.
- **Legacy mode:** `gen_speed`=0, `lane_0_rx_enc`[7:0]=8'hA5 with `sym_valid`=1 -> `lane_0_rx`=8'hA5 and `rx_valid`=1 the next cycle, `sym_ready` always 1.
- **Abort and clear:** during Gen4 unload, `idx`=5:
  - `enable`=0 for one cycle -> all outputs 0 and `idx`=0; with `enable` back high, the next symbol starts at byte 0.
  - the same with `gen_speed` switched to 2 -> abort with no `sync_err`.
